// File: rtl/clk_div_prog_pkg.sv
// clk_div_prog_pkg: shared limits, channel config record and channel FSM states for clk_div_prog.
package clk_div_prog_pkg;
    localparam int MAX_CH  = 8;
    localparam int MIN_DIV = 2;
    localparam int CFG_W   = 16;
    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } ch_cfg_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_t;
endpackage

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: configuration request bus (valid/ready handshake plus reject pulse).
interface clk_div_prog_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_high;
    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_prog_ch.sv
// clk_div_prog_ch: one divider channel with period counter, active/pending config and IDLE/RUN/DRAIN enable FSM.
module clk_div_prog_ch
    import clk_div_prog_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1
) (
    input  logic    clk,
    input  logic    w_rst,
    input  logic    i_en,
    input  logic    i_sync,
    input  logic    i_wr,
    input  ch_cfg_t i_cfg,
    output logic    o_pend,
    output logic    o_clk,
    output logic    o_tick
);
    localparam ch_cfg_t RST_CFG = '{div: CFG_W'(DEF_DIV), high: CFG_W'(DEF_HIGH)};
    ch_state_t        r_st;
    logic [DIV_W-1:0] r_cnt;
    ch_cfg_t          r_act, r_pend;
    logic             r_pv, r_clk, r_tick;
    logic [DIV_W-1:0] w_inc;
    logic             w_last, w_start, w_stop, w_load;
    assign w_inc   = r_cnt + DIV_W'(1);
    assign w_last  = (r_st != IDLE) && (CFG_W'(w_inc) == r_act.div);
    assign w_start = i_en && (r_st == IDLE || w_last || i_sync);
    assign w_stop  = !i_en && w_last;
    // new config only lands where a period starts or while nothing is being output
    assign w_load  = r_pv && (r_st == IDLE || w_last || w_start);
    always_ff @(posedge clk or negedge w_rst) begin
        if (!w_rst) begin
            r_st   <= IDLE;
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_act  <= RST_CFG;
            r_pend <= RST_CFG;
            r_pv   <= 1'b0;
        end else begin
            r_tick <= w_start;
            if (w_start) begin
                r_st  <= RUN;
                r_cnt <= '0;
                r_clk <= 1'b1;
            end else if (w_stop) begin
                r_st  <= IDLE;
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (r_st != IDLE) begin
                r_st  <= i_en ? RUN : DRAIN;
                r_cnt <= w_inc;
                r_clk <= CFG_W'(w_inc) < r_act.high;
            end
            if (w_load) begin
                r_act <= r_pend;
                r_pv  <= 1'b0;
            end else if (i_wr) begin
                r_pend <= i_cfg;
                r_pv   <= 1'b1;
            end
        end
    end
    assign o_pend = r_pv;
    assign o_clk  = r_clk;
    assign o_tick = r_tick;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: NUM_CH programmable clock dividers with glitch-free reconfiguration.
// Define CLK_DIV_PROG_SYNC_EN to add the sync_req phase-alignment input.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 8,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1
) (
    input  logic              clk,
    input  logic              w_rst,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic              sync_req,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    clk_div_prog_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    if (NUM_CH < 1 || NUM_CH > MAX_CH || DIV_W > CFG_W) begin : g_bad_param
        $error("clk_div_prog: unsupported NUM_CH or DIV_W");
    end
    logic [NUM_CH-1:0]      w_pend;
    logic [(1<<CH_W)-1:0]   w_busy;
    logic                   w_sync, w_acc, w_legal, r_err;
    ch_cfg_t                w_cfg;
`ifdef CLK_DIV_PROG_SYNC_EN
    assign w_sync = sync_req;
`else
    assign w_sync = 1'b0;
`endif
    // unused channel codes read as never busy so bad requests still handshake and get rejected
    always_comb begin
        w_busy = '0;
        w_busy[NUM_CH-1:0] = w_pend;
    end
    assign cfg.cfg_ready = !w_busy[cfg.cfg_ch];
    assign w_acc   = cfg.cfg_valid && cfg.cfg_ready;
    assign w_legal = (32'(cfg.cfg_ch) < NUM_CH) && (cfg.cfg_div >= DIV_W'(MIN_DIV))
                     && (cfg.cfg_high != '0) && (cfg.cfg_high < cfg.cfg_div);
    assign w_cfg   = '{div: CFG_W'(cfg.cfg_div), high: CFG_W'(cfg.cfg_high)};
    always_ff @(posedge clk or negedge w_rst) begin
        if (!w_rst) r_err <= 1'b0;
        else        r_err <= w_acc && !w_legal;
    end
    assign cfg.cfg_err = r_err;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_prog_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HIGH(DEF_HIGH)
        ) u_ch (
            .clk   (clk),
            .w_rst (w_rst),
            .i_en  (ch_en[i]),
            .i_sync(w_sync),
            .i_wr  (w_acc && w_legal && cfg.cfg_ch == CH_W'(i)),
            .i_cfg (w_cfg),
            .o_pend(w_pend[i]),
            .o_clk (clk_out[i]),
            .o_tick(tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog with three channels.
module tb_clk_div_prog;
    logic       clk;
    logic       w_rst;
    logic [2:0] ch_en;
    logic [2:0] clk_out;
    logic [2:0] tick;
`ifdef CLK_DIV_PROG_SYNC_EN
    logic       sync_req;
`endif
    int n_run;
    int n_fail;
    clk_div_prog_if #(.NUM_CH(3), .DIV_W(8)) cif ();
    clk_div_prog #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(2), .DEF_HIGH(1)) dut (
        .clk    (clk),
        .w_rst  (w_rst),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync_req(sync_req),
`endif
        .ch_en  (ch_en),
        .cfg    (cif),
        .clk_out(clk_out),
        .tick   (tick)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_run++; if (clk_out !== 3'b000) begin n_fail++; $display("FAIL reset_clk got=%b want=000", clk_out); end
        n_run++; if (tick !== 3'b000) begin n_fail++; $display("FAIL reset_tick got=%b want=000", tick); end
        n_run++; if (cif.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", cif.cfg_err); end
        n_run++; if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", cif.cfg_ready); end
        w_rst = 1'b1;
        step();
        n_run++; if (clk_out !== 3'b000) begin n_fail++; $display("FAIL idle_clk got=%b want=000", clk_out); end
    endtask
    task automatic test_default;
        logic [2:0] e;
        ch_en = 3'b001;
        for (int k = 0; k < 8; k++) begin
            step();
            e = (k % 2 == 0) ? 3'b001 : 3'b000;
            n_run++; if (clk_out !== e) begin n_fail++; $display("FAIL default_clk k=%0d got=%b want=%b", k, clk_out, e); end
            n_run++; if (tick !== e) begin n_fail++; $display("FAIL default_tick k=%0d got=%b want=%b", k, tick, e); end
        end
    endtask
    task automatic test_reconfig;
        logic e, t;
        step();
        cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd0; cif.cfg_div = 8'd5; cif.cfg_high = 8'd2;
        #1;
        n_run++; if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reconf_ready_pre got=%b want=1", cif.cfg_ready); end
        step();
        cif.cfg_valid = 1'b0;
        #1;
        n_run++; if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reconf_ready_pend got=%b want=0", cif.cfg_ready); end
        n_run++; if (clk_out !== 3'b000) begin n_fail++; $display("FAIL reconf_old_period got=%b want=000", clk_out); end
        for (int j = 0; j < 10; j++) begin
            step();
            e = (j % 5) < 2;
            t = (j % 5) == 0;
            n_run++; if (clk_out !== {2'b00, e}) begin n_fail++; $display("FAIL reconf_clk j=%0d got=%b want=%b", j, clk_out, {2'b00, e}); end
            n_run++; if (tick !== {2'b00, t}) begin n_fail++; $display("FAIL reconf_tick j=%0d got=%b want=%b", j, tick, {2'b00, t}); end
            if (j == 0) begin
                n_run++; if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reconf_ready_post got=%b want=1", cif.cfg_ready); end
            end
        end
    endtask
    task automatic test_errors;
        logic [1:0] chs [3] = '{2'd0, 2'd0, 2'd3};
        logic [7:0] divs[3] = '{8'd1, 8'd4, 8'd4};
        logic [7:0] his [3] = '{8'd1, 8'd4, 8'd2};
        int ph = 4;
        for (int v = 0; v < 3; v++) begin
            cif.cfg_valid = 1'b1; cif.cfg_ch = chs[v]; cif.cfg_div = divs[v]; cif.cfg_high = his[v];
            step();
            ph = (ph + 1) % 5;
            cif.cfg_valid = 1'b0; cif.cfg_ch = 2'd0;
            n_run++; if (cif.cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse v=%0d got=%b want=1", v, cif.cfg_err); end
            n_run++; if (clk_out[0] !== (ph < 2)) begin n_fail++; $display("FAIL err_clk v=%0d got=%b want=%b", v, clk_out[0], ph < 2); end
            step();
            ph = (ph + 1) % 5;
            n_run++; if (cif.cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_single v=%0d got=%b want=0", v, cif.cfg_err); end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            ph = (ph + 1) % 5;
            n_run++; if (clk_out !== {2'b00, ph < 2}) begin n_fail++; $display("FAIL err_active k=%0d got=%b want=%b", k, clk_out, {2'b00, ph < 2}); end
            n_run++; if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_nopend k=%0d got=%b want=1", k, cif.cfg_ready); end
        end
    endtask
    task automatic test_drain;
        logic [13:0] en_v  = 14'b11110110000001;
        logic [13:0] clk_v = 14'b10001110000011;
        logic [13:0] tck_v = 14'b10000010000000;
        bit got = 0;
        cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd0; cif.cfg_div = 8'd6; cif.cfg_high = 8'd3;
        step();
        cif.cfg_valid = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            step();
            got = tick[0] && cif.cfg_ready;
        end
        n_run++; if (!got) begin n_fail++; $display("FAIL drain_wait got=no_boundary want=boundary"); end
        for (int s = 0; s < 14; s++) begin
            ch_en = {2'b00, en_v[s]};
            step();
            n_run++; if (clk_out !== {2'b00, clk_v[s]}) begin n_fail++; $display("FAIL drain_clk s=%0d got=%b want=%b", s + 1, clk_out, {2'b00, clk_v[s]}); end
            n_run++; if (tick !== {2'b00, tck_v[s]}) begin n_fail++; $display("FAIL drain_tick s=%0d got=%b want=%b", s + 1, tick, {2'b00, tck_v[s]}); end
        end
    endtask
    task automatic test_reset_mid;
        logic [2:0] e;
        cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd0; cif.cfg_div = 8'd3; cif.cfg_high = 8'd1;
        step();
        cif.cfg_valid = 1'b0;
        #1;
        n_run++; if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pend got=%b want=0", cif.cfg_ready); end
        n_run++; if (clk_out !== 3'b001) begin n_fail++; $display("FAIL rmid_pre_clk got=%b want=001", clk_out); end
        #1;
        w_rst = 1'b0;
        #1;
        n_run++; if (clk_out !== 3'b000) begin n_fail++; $display("FAIL rmid_async_clk got=%b want=000", clk_out); end
        n_run++; if (tick !== 3'b000) begin n_fail++; $display("FAIL rmid_async_tick got=%b want=000", tick); end
        n_run++; if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_pend_clr got=%b want=1", cif.cfg_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_run++; if (clk_out !== 3'b000) begin n_fail++; $display("FAIL rmid_hold got=%b want=000", clk_out); end
        w_rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            e = (k % 2 == 0) ? 3'b001 : 3'b000;
            n_run++; if (clk_out !== e) begin n_fail++; $display("FAIL rmid_clk k=%0d got=%b want=%b", k, clk_out, e); end
            n_run++; if (tick !== e) begin n_fail++; $display("FAIL rmid_tick k=%0d got=%b want=%b", k, tick, e); end
        end
    endtask
`ifdef CLK_DIV_PROG_SYNC_EN
    task automatic test_sync;
        logic [2:0] ec, et;
        ch_en = 3'b000;
        repeat (6) step();
        cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd0; cif.cfg_div = 8'd3; cif.cfg_high = 8'd1;
        step();
        cif.cfg_ch = 2'd1; cif.cfg_div = 8'd4; cif.cfg_high = 8'd2;
        step();
        cif.cfg_valid = 1'b0; cif.cfg_ch = 2'd0;
        step();
        ch_en = 3'b001;
        repeat (2) step();
        ch_en = 3'b011;
        step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            ec = {1'b0, (k % 4) < 2, (k % 3) == 0};
            et = {1'b0, (k % 4) == 0, (k % 3) == 0};
            n_run++; if (clk_out !== ec) begin n_fail++; $display("FAIL sync_clk k=%0d got=%b want=%b", k, clk_out, ec); end
            n_run++; if (tick !== et) begin n_fail++; $display("FAIL sync_tick k=%0d got=%b want=%b", k, tick, et); end
        end
    endtask
`endif
    initial begin
        n_run = 0;
        n_fail = 0;
        w_rst = 1'b0;
        ch_en = 3'b000;
`ifdef CLK_DIV_PROG_SYNC_EN
        sync_req = 1'b0;
`endif
        cif.cfg_valid = 1'b0;
        cif.cfg_ch = 2'd0;
        cif.cfg_div = 8'd0;
        cif.cfg_high = 8'd0;
        test_reset();
        test_default();
        test_reconfig();
        test_errors();
        test_drain();
        test_reset_mid();
`ifdef CLK_DIV_PROG_SYNC_EN
        test_sync();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
